// File: rtl/regbank_pkg.sv
// Shared constants for the parametrised register bank: function-select encodings and lane width.
package regbank_pkg;
  localparam int LANE_W = 8;

  localparam logic [2:0] FS_DEC    = 3'b000;
  localparam logic [2:0] FS_INC    = 3'b001;
  localparam logic [2:0] FS_LOAD   = 3'b010;
  localparam logic [2:0] FS_CLR    = 3'b011;
  localparam logic [2:0] FS_LDLO_Z = 3'b100;
  localparam logic [2:0] FS_LDLANE = 3'b101;
  localparam logic [2:0] FS_SHIN   = 3'b110;
  localparam logic [2:0] FS_LDLO_S = 3'b111;
endpackage

// File: rtl/param_register_bank_reg_cell.sv
// One bank register with its sticky overflow flag; implements the complete FunSel operation table.
module reg_cell
  import regbank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               BSEL_W    = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              En,
  input  logic [WIDTH-1:0]  I,
  input  logic [2:0]        FunSel,
  input  logic [BSEL_W-1:0] ByteSel,
  input  logic              SatMode,
  output logic [WIDTH-1:0]  R,
  output logic              Ovf
);
  localparam int               NLANES = WIDTH / LANE_W;
  localparam logic [WIDTH-1:0] ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q, r_nxt;
  logic             ovf_q, ovf_nxt;

  always_comb begin
    r_nxt   = r_q;
    ovf_nxt = ovf_q;
    unique case (FunSel)
      FS_DEC: begin
        if (r_q == '0) begin
          r_nxt   = SatMode ? '0 : '1;
          ovf_nxt = 1'b1;
        end else begin
          r_nxt = r_q - ONE;
        end
      end
      FS_INC: begin
        if (r_q == '1) begin
          r_nxt   = SatMode ? '1 : '0;
          ovf_nxt = 1'b1;
        end else begin
          r_nxt = r_q + ONE;
        end
      end
      FS_LOAD: begin
        r_nxt   = I;
        ovf_nxt = 1'b0;
      end
      FS_CLR: begin
        r_nxt   = '0;
        ovf_nxt = 1'b0;
      end
      FS_LDLO_Z: begin
        r_nxt   = {{(WIDTH-LANE_W){1'b0}}, I[LANE_W-1:0]};
        ovf_nxt = 1'b0;
      end
      FS_LDLANE: begin
        // Lane indices past the last lane match nothing, so the register holds.
        for (int k = 0; k < NLANES; k++) begin
          if (ByteSel == BSEL_W'(k)) r_nxt[k*LANE_W +: LANE_W] = I[LANE_W-1:0];
        end
      end
      FS_SHIN: r_nxt = {r_q[WIDTH-LANE_W-1:0], I[LANE_W-1:0]};
      default: begin
        r_nxt   = {{(WIDTH-LANE_W){I[LANE_W-1]}}, I[LANE_W-1:0]};
        ovf_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_q   <= RESET_VAL;
      ovf_q <= 1'b0;
    end else if (En) begin
      r_q   <= r_nxt;
      ovf_q <= ovf_nxt;
    end
  end

  assign R   = r_q;
  assign Ovf = ovf_q;
endmodule

// File: rtl/param_register_bank.sv
// Bank of NUM_REGS registers sharing one write bus and function select, with two combinational read ports.
module param_register_bank
  import regbank_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               NUM_REGS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int BSEL_W = (WIDTH / LANE_W > 1) ? $clog2(WIDTH / LANE_W) : 1,
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [WIDTH-1:0]    I,
  input  logic [NUM_REGS-1:0] RegSel,
  input  logic [2:0]          FunSel,
  input  logic [BSEL_W-1:0]   ByteSel,
  input  logic                SatMode,
  input  logic [SEL_W-1:0]    OutASel,
  input  logic [SEL_W-1:0]    OutBSel,
  output logic [WIDTH-1:0]    OutA,
  output logic [WIDTH-1:0]    OutB,
  output logic [NUM_REGS-1:0] OvfFlags
);
  logic [WIDTH-1:0] regs [NUM_REGS];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    reg_cell #(
      .WIDTH    (WIDTH),
      .BSEL_W   (BSEL_W),
      .RESET_VAL(RESET_VAL)
    ) u_cell (
      .Clock  (Clock),
      .Reset  (Reset),
      .En     (RegSel[g]),
      .I      (I),
      .FunSel (FunSel),
      .ByteSel(ByteSel),
      .SatMode(SatMode),
      .R      (regs[g]),
      .Ovf    (OvfFlags[g])
    );
  end

  // Unmatched select codes (index >= NUM_REGS) fall through to zero.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (OutASel == SEL_W'(k)) OutA = regs[k];
      if (OutBSel == SEL_W'(k)) OutB = regs[k];
    end
  end
endmodule

// File: tb/tb_param_register_bank.sv
// Directed-vector bench for param_register_bank at WIDTH=16, NUM_REGS=4, RESET_VAL=0.
module tb_param_register_bank;
  import regbank_pkg::*;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [15:0] I;
  logic [3:0]  RegSel;
  logic [2:0]  FunSel;
  logic [0:0]  ByteSel;
  logic        SatMode;
  logic [1:0]  OutASel, OutBSel;
  logic [15:0] OutA, OutB;
  logic [3:0]  OvfFlags;

  int errors = 0;
  int checks = 0;
  logic [15:0] rv [4];
  logic [15:0] ev [4];

  param_register_bank #(.WIDTH(16), .NUM_REGS(4), .RESET_VAL(16'h0000)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .RegSel(RegSel), .FunSel(FunSel),
    .ByteSel(ByteSel), .SatMode(SatMode), .OutASel(OutASel), .OutBSel(OutBSel),
    .OutA(OutA), .OutB(OutB), .OvfFlags(OvfFlags)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic op(input logic [3:0] rs, input logic [2:0] fs, input logic [15:0] d,
                    input logic bs, input logic sat);
    RegSel = rs; FunSel = fs; I = d; ByteSel = bs; SatMode = sat;
    tick();
    RegSel = 4'b0000;
  endtask

  task automatic snap();
    for (int k = 0; k < 4; k++) begin
      OutASel = 2'(k);
      #1;
      rv[k] = OutA;
    end
  endtask

  task automatic test_reset();
    op(4'b1111, FS_LOAD, 16'h1357, 1'b0, 1'b0);
    op(4'b0011, FS_INC, 16'h0000, 1'b0, 1'b0);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    snap();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rv[k] !== 16'h0000) begin
        errors++;
        $display("FAIL reset_R%0d got %h want 0000", k, rv[k]);
      end
    end
    checks++;
    if (OvfFlags !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0000", OvfFlags);
    end
  endtask

  task automatic test_wrap_sat();
    logic [15:0] exp_r [4];
    logic [2:0]  fs [4];
    logic [15:0] init [4];
    logic        sat [4];
    exp_r = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000};
    fs    = '{FS_INC, FS_INC, FS_DEC, FS_DEC};
    init  = '{16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000};
    sat   = '{1'b0, 1'b1, 1'b0, 1'b1};
    OutASel = 2'd0;
    for (int t = 0; t < 4; t++) begin
      op(4'b0001, FS_LOAD, init[t], 1'b0, 1'b0);
      op(4'b0001, fs[t], 16'h0000, 1'b0, sat[t]);
      OutASel = 2'd0;
      #1;
      checks++;
      if (OutA !== exp_r[t]) begin
        errors++;
        $display("FAIL wrapsat_val%0d got %h want %h", t, OutA, exp_r[t]);
      end
      checks++;
      if (OvfFlags[0] !== 1'b1) begin
        errors++;
        $display("FAIL wrapsat_ovf%0d got %b want 1", t, OvfFlags[0]);
      end
    end
  endtask

  task automatic test_lanes();
    logic [2:0]  fs [5];
    logic [15:0] d [5];
    logic        bs [5];
    logic [15:0] exp_r [5];
    fs    = '{FS_LDLANE, FS_SHIN, FS_LDLO_S, FS_LDLO_Z, FS_LDLANE};
    d     = '{16'h00AB, 16'h00CD, 16'h0080, 16'hFF80, 16'hEE11};
    bs    = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    exp_r = '{16'hAB34, 16'h34CD, 16'hFF80, 16'h0080, 16'h0011};
    op(4'b0010, FS_LOAD, 16'h1234, 1'b0, 1'b0);
    for (int t = 0; t < 5; t++) begin
      op(4'b0010, fs[t], d[t], bs[t], 1'b0);
      OutBSel = 2'd1;
      #1;
      checks++;
      if (OutB !== exp_r[t]) begin
        errors++;
        $display("FAIL lane_op%0d got %h want %h", t, OutB, exp_r[t]);
      end
    end
  endtask

  task automatic test_multi_enable();
    op(4'b0001, FS_LOAD, 16'h1000, 1'b0, 1'b0);
    op(4'b0010, FS_LOAD, 16'h1111, 1'b0, 1'b0);
    op(4'b0100, FS_LOAD, 16'h2222, 1'b0, 1'b0);
    op(4'b1000, FS_LOAD, 16'h3333, 1'b0, 1'b0);
    OutASel = 2'd1; OutBSel = 2'd3;
    RegSel = 4'b1010; FunSel = FS_LOAD; I = 16'h5A5A;
    #1;
    checks++;
    if (OutA !== 16'h1111 || OutB !== 16'h3333) begin
      errors++;
      $display("FAIL multi_prewrite got %h/%h want 1111/3333", OutA, OutB);
    end
    tick();
    RegSel = 4'b0000;
    checks++;
    if (OutA !== 16'h5A5A || OutB !== 16'h5A5A) begin
      errors++;
      $display("FAIL multi_postwrite got %h/%h want 5a5a/5a5a", OutA, OutB);
    end
    ev = '{16'h1000, 16'h5A5A, 16'h2222, 16'h5A5A};
    snap();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rv[k] !== ev[k]) begin
        errors++;
        $display("FAIL multi_R%0d got %h want %h", k, rv[k], ev[k]);
      end
    end
    OutASel = 2'd2; OutBSel = 2'd2;
    #1;
    checks++;
    if (OutA !== 16'h2222 || OutB !== 16'h2222) begin
      errors++;
      $display("FAIL same_sel got %h/%h want 2222/2222", OutA, OutB);
    end
  endtask

  task automatic test_sticky();
    op(4'b0100, FS_LOAD, 16'hFFFF, 1'b0, 1'b0);
    op(4'b0100, FS_INC, 16'h0000, 1'b0, 1'b0);
    op(4'b0100, FS_INC, 16'h0000, 1'b0, 1'b0);
    op(4'b0100, FS_INC, 16'h0000, 1'b0, 1'b0);
    OutASel = 2'd2;
    #1;
    checks++;
    if (OutA !== 16'h0002) begin
      errors++;
      $display("FAIL sticky_val got %h want 0002", OutA);
    end
    checks++;
    if (OvfFlags !== 4'b0100) begin
      errors++;
      $display("FAIL sticky_ovf got %b want 0100", OvfFlags);
    end
    op(4'b0100, FS_SHIN, 16'h0077, 1'b0, 1'b0);
    checks++;
    if (OutA !== 16'h0277 || OvfFlags[2] !== 1'b1) begin
      errors++;
      $display("FAIL sticky_shin got %h/%b want 0277/1", OutA, OvfFlags[2]);
    end
    op(4'b0100, FS_CLR, 16'hFFFF, 1'b0, 1'b0);
    checks++;
    if (OutA !== 16'h0000 || OvfFlags[2] !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr got %h/%b want 0000/0", OutA, OvfFlags[2]);
    end
  endtask

  task automatic test_reset_vs_write();
    op(4'b0001, FS_DEC, 16'h0000, 1'b0, 1'b0);
    op(4'b0110, FS_LOAD, 16'h4321, 1'b0, 1'b0);
    Reset = 1'b1; RegSel = 4'b1111; FunSel = FS_LOAD; I = 16'hBEEF;
    tick();
    Reset = 1'b0; RegSel = 4'b0000;
    snap();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rv[k] !== 16'h0000) begin
        errors++;
        $display("FAIL rstwr_R%0d got %h want 0000", k, rv[k]);
      end
    end
    checks++;
    if (OvfFlags !== 4'b0000) begin
      errors++;
      $display("FAIL rstwr_ovf got %b want 0000", OvfFlags);
    end
  endtask

  initial begin
    Reset = 1'b1; I = '0; RegSel = '0; FunSel = FS_LOAD; ByteSel = '0; SatMode = 1'b0;
    OutASel = '0; OutBSel = '0;
    tick();
    tick();
    Reset = 1'b0;
    test_reset();
    test_wrap_sat();
    test_lanes();
    test_multi_enable();
    test_sticky();
    test_reset_vs_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
